// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count, threshold flags,
// sticky overflow/underflow flags and a selectable first-word-fall-through read port.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int FWFT       = 0,
    parameter int AFULL_TH   = 6,
    parameter int AEMPTY_TH  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  R_INC,
    input  logic                  ERR_CLR,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH+1)'(AEMPTY_TH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ptr_msb_unused;

    // Occupancy lives in its own counter, so the pointer wrap bits only
    // document the modulo-2*DEPTH pointer arithmetic.
    assign ptr_msb_unused = wr_ptr[ADDR_WIDTH] ^ rd_ptr[ADDR_WIDTH];

    assign wr_acc = W_INC & ~FULL;
    assign rd_acc = R_INC & ~EMPTY;

    always_comb begin
        count_next = COUNT;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = COUNT + 1'b1;
            2'b01:   count_next = COUNT - 1'b1;
            default: count_next = COUNT;
        endcase
    end

    // Flags are registered from the next count so they always match COUNT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            COUNT        <= '0;
            FULL         <= 1'b0;
            EMPTY        <= 1'b1;
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
            OVERFLOW     <= 1'b0;
            UNDERFLOW    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_acc) begin
                mem[wr_ptr[ADDR_WIDTH-1:0]] <= WR_DATA;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            COUNT        <= count_next;
            FULL         <= (count_next == DEPTH_CNT);
            EMPTY        <= (count_next == '0);
            ALMOST_FULL  <= (count_next >= AFULL_CNT);
            ALMOST_EMPTY <= (count_next <= AEMPTY_CNT);
            // A new error in the same cycle as a clear must stay visible.
            if (W_INC & FULL) begin
                OVERFLOW <= 1'b1;
            end else if (ERR_CLR) begin
                OVERFLOW <= 1'b0;
            end
            if (R_INC & EMPTY) begin
                UNDERFLOW <= 1'b1;
            end else if (ERR_CLR) begin
                UNDERFLOW <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign RD_DATA  = mem[rd_ptr[ADDR_WIDTH-1:0]];
            assign RD_VALID = ~EMPTY;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                    end
                end
            end

            assign RD_DATA  = rd_data_q;
            assign RD_VALID = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Drives one standard-read and one FWFT FIFO with identical stimulus and
// compares both against a queue-based model of the FIFO rules.
module tb_sync_fifo;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       W_INC = 1'b0;
    logic [7:0] WR_DATA = 8'h00;
    logic       R_INC = 1'b0;
    logic       ERR_CLR = 1'b0;

    logic [7:0] rd_data0, rd_data1;
    logic       rd_valid0, rd_valid1;
    logic       full0, full1, empty0, empty1;
    logic       afull0, afull1, aempty0, aempty1;
    logic [3:0] count0, count1;
    logic       ovf0, ovf1, unf0, unf1;

    int total = 0;
    int bad = 0;

    logic [7:0] q[$];
    logic       m_ovf, m_unf, m_rv0, m_just_reset;
    logic [7:0] m_rd0;

    always #5 CLK = ~CLK;

    sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(1)) dut0 (
        .CLK(CLK), .RST(RST), .W_INC(W_INC), .WR_DATA(WR_DATA), .R_INC(R_INC), .ERR_CLR(ERR_CLR),
        .RD_DATA(rd_data0), .RD_VALID(rd_valid0), .FULL(full0), .EMPTY(empty0),
        .ALMOST_FULL(afull0), .ALMOST_EMPTY(aempty0), .COUNT(count0),
        .OVERFLOW(ovf0), .UNDERFLOW(unf0)
    );

    sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(1)) dut1 (
        .CLK(CLK), .RST(RST), .W_INC(W_INC), .WR_DATA(WR_DATA), .R_INC(R_INC), .ERR_CLR(ERR_CLR),
        .RD_DATA(rd_data1), .RD_VALID(rd_valid1), .FULL(full1), .EMPTY(empty1),
        .ALMOST_FULL(afull1), .ALMOST_EMPTY(aempty1), .COUNT(count1),
        .OVERFLOW(ovf1), .UNDERFLOW(unf1)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // Model state advances with the same inputs the DUTs saw at this edge.
    task automatic modelUpdate(input logic w, input logic [7:0] d, input logic r,
                               input logic clr, input logic rst);
        logic was_full, was_empty;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rv0 = 1'b0;
            m_rd0 = 8'h00;
            m_just_reset = 1'b1;
        end else begin
            was_full  = (q.size() == 8);
            was_empty = (q.size() == 0);
            m_rv0 = 1'b0;
            m_just_reset = 1'b0;
            if (r && !was_empty) begin
                m_rd0 = q.pop_front();
                m_rv0 = 1'b1;
            end
            if (w && !was_full) q.push_back(d);
            if (w && was_full) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (r && was_empty) m_unf = 1'b1;
            else if (clr) m_unf = 1'b0;
        end
    endtask

    task automatic checkOutput();
        int n;
        n = q.size();
        checkVal("count0", 32'(count0), 32'(n));
        checkVal("count1", 32'(count1), 32'(n));
        checkVal("full0", 32'(full0), 32'(n == 8));
        checkVal("full1", 32'(full1), 32'(n == 8));
        checkVal("empty0", 32'(empty0), 32'(n == 0));
        checkVal("empty1", 32'(empty1), 32'(n == 0));
        checkVal("afull0", 32'(afull0), 32'(n >= 6));
        checkVal("afull1", 32'(afull1), 32'(n >= 6));
        checkVal("aempty0", 32'(aempty0), 32'(n <= 1));
        checkVal("aempty1", 32'(aempty1), 32'(n <= 1));
        checkVal("ovf0", 32'(ovf0), 32'(m_ovf));
        checkVal("ovf1", 32'(ovf1), 32'(m_ovf));
        checkVal("unf0", 32'(unf0), 32'(m_unf));
        checkVal("unf1", 32'(unf1), 32'(m_unf));
        checkVal("rd_valid0", 32'(rd_valid0), 32'(m_rv0));
        checkVal("rd_data0", 32'(rd_data0), 32'(m_rd0));
        checkVal("rd_valid1", 32'(rd_valid1), 32'(n != 0));
        if (n != 0) checkVal("rd_data1", 32'(rd_data1), 32'(q[0]));
        else if (m_just_reset) checkVal("rd_data1_rst", 32'(rd_data1), 32'h0);
    endtask

    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r,
                                 input logic clr, input logic rst);
        W_INC = w;
        WR_DATA = d;
        R_INC = r;
        ERR_CLR = clr;
        RST = rst;
        @(posedge CLK);
        modelUpdate(w, d, r, clr, rst);
        #1;
        checkOutput();
    endtask

    initial begin
        logic w, r, clr, rst;
        logic [7:0] d;

        // Reset
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Fill 0x10..0x17, then a dropped 0xFF
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Simultaneous at full: read wins, write dropped
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h18, 1'b0, 1'b1, 1'b0);

        // Drain from full plus one extra read
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Simultaneous at empty: write wins, underflow
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);

        // Error set and clear in the same cycle: set wins
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Simultaneous at count 4
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);

        // FWFT fall-through of a single word
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Preload 3, then 20 cycles of concurrent traffic across two wraps
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);

        // Reset mid-operation at count 5 with overflow set; write in reset cycle ignored
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with fill-biased and drain-biased phases
        for (int i = 0; i < 600; i++) begin
            if ((i / 100) % 2 == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            clr = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 79) == 0);
            d = 8'($urandom);
            applyStimulus(w, d, r, clr, rst);
        end

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
